alu_seq: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Adds XOR, signed/unsigned compare and shifts as registered 1-cycle ops.
- Adds iterative multiply and divide/remainder (RV32M-style subset) behind a Start/Busy/Done handshake.
- Sits in the execute stage; the controller stalls on Busy.

---
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU; 1-cycle logic/shift/compare ops plus
// optional iterative MUL/MULHU/DIV/DIVU/REM/REMU (macro ALU_SEQ_MULDIV_EN).
// Ports: clk, reset (async, active-high), Start, SrcA, SrcB, ALUControl in;
// Busy, Done (1-cycle pulse), Zero, ALUResult (registered) out.
// With ALU_SEQ_MULDIV_EN undefined, codes 1010-1111 return 0 in one cycle.
module alu_seq #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [width-1:0] SrcA,
    input  logic [width-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             Busy,
    output logic             Done,
    output logic             Zero,
    output logic [width-1:0] ALUResult
);
    localparam int SW = $clog2(width);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] result_q, res_d;
    logic             zero_q;
    logic             done_q, done_d;
    logic             load;
    logic [width-1:0] alu_y;
    logic [SW-1:0]    shamt;

    assign shamt = SrcB[SW-1:0];

    always_comb begin
        alu_y = '0;
        unique case (ALUControl)
            4'b0000: alu_y = SrcA + SrcB;
            4'b0001: alu_y = SrcA - SrcB;
            4'b0010: alu_y = SrcA & SrcB;
            4'b0011: alu_y = SrcA | SrcB;
            4'b0100: alu_y = SrcA ^ SrcB;
            4'b0101: alu_y = {{(width-1){1'b0}},
                              $signed(SrcA) < $signed(SrcB)};
            4'b0110: alu_y = {{(width-1){1'b0}}, SrcA < SrcB};
            4'b0111: alu_y = SrcA << shamt;
            4'b1000: alu_y = SrcA >> shamt;
            4'b1001: alu_y = $signed(SrcA) >>> shamt;
            default: alu_y = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic [3:0]         op_q, op_d;
    logic [width-1:0]   opa_q, opa_d;
    logic [width-1:0]   opb_q, opb_d;
    // MUL: {partial high, remaining multiplier}; DIV: {rem, quotient}
    logic [2*width-1:0] acc_q, acc_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;

    logic               is_md, sgn;
    logic [width-1:0]   mag_a, mag_b;
    logic [width-1:0]   mul_add;
    logic [width:0]     mul_sum;
    logic [2*width-1:0] mul_nx, div_nx;
    logic [width:0]     div_trial;
    logic [width-1:0]   quo, rem, md_res;

    assign is_md = ALUControl[3] & (ALUControl[2] | ALUControl[1]);
    assign sgn   = ALUControl[2] & ~ALUControl[0];
    assign mag_a = (sgn & SrcA[width-1]) ? -SrcA : SrcA;
    assign mag_b = (sgn & SrcB[width-1]) ? -SrcB : SrcB;

    assign mul_add = acc_q[0] ? opa_q : '0;
    assign mul_sum = {1'b0, acc_q[2*width-1:width]} + {1'b0, mul_add};
    assign mul_nx  = {mul_sum, acc_q[width-1:1]};

    // Trial subtract of the divisor from {rem, next dividend bit}
    assign div_trial = acc_q[2*width-1:width-1] - {1'b0, opb_q};
    assign div_nx = div_trial[width]
                  ? {acc_q[2*width-2:0], 1'b0}
                  : {div_trial[width-1:0], acc_q[width-2:0], 1'b1};

    assign quo = div_nx[width-1:0];
    assign rem = div_nx[2*width-1:width];

    always_comb begin
        md_res = '0;
        if (!op_q[2])
            md_res = op_q[0] ? mul_nx[2*width-1:width] : mul_nx[width-1:0];
        else if (!op_q[1])
            md_res = dz_q ? '1 : (qneg_q ? -quo : quo);
        else
            md_res = dz_q ? opa_q : (rneg_q ? -rem : rem);
    end
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        res_d   = alu_y;
`ifdef ALU_SEQ_MULDIV_EN
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_md) begin
                        state_d = ALUControl[2] ? S_DIV : S_MUL;
                        op_d    = ALUControl;
                        opa_d   = SrcA;
                        opb_d   = mag_b;
                        acc_d   = ALUControl[2]
                                ? {{width{1'b0}}, mag_a}
                                : {{width{1'b0}}, SrcB};
                        cnt_d   = '0;
                        qneg_d  = sgn & (SrcA[width-1] ^ SrcB[width-1]);
                        rneg_d  = sgn & SrcA[width-1];
                        dz_d    = (SrcB == '0);
                    end else begin
                        load   = 1'b1;
                        done_d = 1'b1;
                    end
`else
                    load   = 1'b1;
                    done_d = 1'b1;
`endif
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_nx : div_nx;
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == '1) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                    done_d  = 1'b1;
                    res_d   = md_res;
                end
            end
`else
            S_MUL, S_DIV: state_d = S_IDLE;
`endif
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
            end
`ifdef ALU_SEQ_MULDIV_EN
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
`endif
        end
    end

`ifdef ALU_SEQ_MULDIV_EN
    assign Busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign Busy = 1'b0;
`endif
    assign Done      = done_q;
    assign Zero      = zero_q;
    assign ALUResult = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq (width=32, plus width=16
// multiply when ALU_SEQ_MULDIV_EN is defined).
module tb_alu_seq;
    localparam int W = 32;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] AND_ = 4'b0010;
    localparam logic [3:0] OR_  = 4'b0011;
    localparam logic [3:0] XOR_ = 4'b0100;
    localparam logic [3:0] SLT  = 4'b0101;
    localparam logic [3:0] SLTU = 4'b0110;
    localparam logic [3:0] SLL  = 4'b0111;
    localparam logic [3:0] SRL  = 4'b1000;
    localparam logic [3:0] SRA  = 4'b1001;
    localparam logic [3:0] MUL  = 4'b1010;
    localparam logic [3:0] MULH = 4'b1011;
    localparam logic [3:0] DIV  = 4'b1100;
    localparam logic [3:0] DIVU = 4'b1101;
    localparam logic [3:0] REM  = 4'b1110;
    localparam logic [3:0] REMU = 4'b1111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   ctl;
    logic         busy, done, zero;
    logic [W-1:0] res;

    int n_cmp = 0;
    int n_err = 0;
    int dcyc, bcnt;

    always #5 clk = ~clk;

    alu_seq #(.width(W)) dut (
        .clk(clk), .reset(reset), .Start(start),
        .SrcA(a), .SrcB(b), .ALUControl(ctl),
        .Busy(busy), .Done(done), .Zero(zero), .ALUResult(res)
    );

`ifdef ALU_SEQ_MULDIV_EN
    logic        start16;
    logic [15:0] a16, b16, res16;
    logic [3:0]  ctl16;
    logic        busy16, done16, zero16;

    alu_seq #(.width(16)) dut16 (
        .clk(clk), .reset(reset), .Start(start16),
        .SrcA(a16), .SrcB(b16), .ALUControl(ctl16),
        .Busy(busy16), .Done(done16), .Zero(zero16), .ALUResult(res16)
    );
`endif

    task automatic chk(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", t, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        ctl   = op;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sc(input string t, input logic [3:0] op,
                      input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] e);
        issue(op, x, y);
        @(negedge clk);
        chk({t, " done"}, 32'(done), 32'd1);
        chk({t, " busy"}, 32'(busy), 32'd0);
        chk({t, " res"}, res, e);
        chk({t, " zero"}, 32'(zero), 32'(e == '0));
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic md(input string t, input logic [3:0] op,
                      input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] e, input bit poke);
        issue(op, x, y);
        dcyc = 0;
        bcnt = 0;
        for (int k = 1; k <= 3 * W; k++) begin
            @(negedge clk);
            if (poke && k == 5) begin
                start = 1'b1;
                ctl   = ADD;
                a     = 32'h1111_1111;
                b     = 32'h2222_2222;
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                dcyc = k;
                break;
            end
        end
        start = 1'b0;
        chk({t, " done cyc"}, 32'(dcyc), 32'(W + 1));
        chk({t, " busy cnt"}, 32'(bcnt), 32'(W));
        chk({t, " res"}, res, e);
        chk({t, " zero"}, 32'(zero), 32'(e == '0));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ctl   = ADD;
`ifdef ALU_SEQ_MULDIV_EN
        start16 = 1'b0;
        a16     = '0;
        b16     = '0;
        ctl16   = ADD;
`endif
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst res", res, 32'd0);
        chk("rst zero", 32'(zero), 32'd1);
        reset = 1'b0;

        sc("ADD 3+4", ADD, 32'd3, 32'd4, 32'd7);
        @(negedge clk);
        chk("idle done", 32'(done), 32'd0);
        chk("idle hold", res, 32'd7);

`ifdef ALU_SEQ_MULDIV_EN
        issue(MUL, 32'h0000_1234, 32'h0000_0005);
        repeat (5) @(posedge clk);
        #1;
        chk("mid busy", 32'(busy), 32'd1);
`endif
        reset = 1'b1;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst res", res, 32'd0);
        chk("arst zero", 32'(zero), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            chk("no done after rst", 32'(done), 32'd0);
        end
        sc("ADD after rst", ADD, 32'd3, 32'd4, 32'd7);

        sc("ADD wrap", ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
        sc("SUB 5-5", SUB, 32'd5, 32'd5, 32'd0);
        sc("AND", AND_, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        sc("OR", OR_, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        sc("XOR", XOR_, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        sc("SLT", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        sc("SLTU", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        sc("SRA", SRA, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
        sc("SRL", SRL, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000);
        sc("SLL", SLL, 32'd1, 32'd31, 32'h8000_0000);

`ifdef ALU_SEQ_MULDIV_EN
        md("MUL", MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        md("MULHU", MULH, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
        md("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        md("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        md("DIVU /0", DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 1'b0);
        md("REMU /0", REMU, 32'd10, 32'd0, 32'd10, 1'b0);
        md("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0);
        md("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        start = 1'b1;
        ctl   = ADD;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start in DONE done", 32'(done), 32'd0);
        chk("start in DONE res", res, 32'd0);

        @(negedge clk);
        start16 = 1'b1;
        ctl16   = MUL;
        a16     = 16'h00FF;
        b16     = 16'h0101;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        dcyc = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done16) begin
                dcyc = k;
                break;
            end
        end
        chk("w16 done cyc", 32'(dcyc), 32'd17);
        chk("w16 res", {16'd0, res16}, 32'h0000_FFFF);
        chk("w16 zero", 32'(zero16), 32'd0);
`else
        sc("MUL off", MUL, 32'hFFFF_FFFF, 32'd2, 32'd0);
        sc("MULHU off", MULH, 32'hFFFF_FFFF, 32'd2, 32'd0);
        sc("DIVU off", DIVU, 32'd10, 32'd3, 32'd0);
        sc("REMU off", REMU, 32'd10, 32'd3, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
